random_sampler: RTL and testbench
=================================

Name: random_sampler

Overview:
Consumer end of the 4-bit random source used by the VGA game logic. It watches the source's 28-bit cycle counter, captures each new 4-bit random value once per period, and buffers the values in an 8-entry FIFO. Game logic pops values through a first-word-fall-through valid/ready port. The block also provides health monitoring: a saturating overflow counter and a sticky "stuck source" flag.

Parameters:
SAMPLE_AT, 2, nanos value at which rand is stable and is captured (the source updates rand one cycle after nanos wraps to 0).
DEPTH, 8, FIFO entries; power of two.
STUCK_LIMIT, 4, number of consecutive identical samples that asserts stuck; legal range 2..15.

Ports:
CLK  input  1  system clock (100 MHz)
reset  input  1  asynchronous, active-low reset
nanos  input  28  cycle counter from the random source
rand  input  4  random value from the random source
flush  input  1  synchronous FIFO clear, active-high
out_ready  input  1  consumer accepts out_data this cycle
out_valid  output  1  FIFO non-empty; out_data valid
out_data  output  4  FIFO head (first-word fall-through)
fill_level  output  4  entries held, 0..DEPTH
overflow_cnt  output  8  samples dropped because the FIFO was full; saturates at 255
stuck  output  1  sticky: STUCK_LIMIT identical consecutive samples seen
sample_strobe  output  1  one-cycle pulse, registered, on each capture

Behaviour:
- Reset: asynchronous, active-low (reset=0). While asserted, all outputs are 0, FIFO is empty, nanos_q is 0 and the repeat tracker is cleared.
- Sample event S in cycle t:
  - Condition: nanos == SAMPLE_AT and nanos_q != SAMPLE_AT, where nanos_q is nanos registered one cycle earlier.
  - If nanos holds at SAMPLE_AT for several cycles, only one sample is taken.
- Capture timing:
  - On S, rand is written at the clock edge that ends cycle t.
  - sample_strobe=1 in cycle t+1.
  - If the FIFO was empty, out_valid=1 and out_data=the captured value in cycle t+1.
- Pop (P): out_valid && out_ready. The head advances at that edge. out_data is undefined, but must be stable-held, when out_valid=0.
- FIFO boundaries:
  - Not full, S without P: level +1.
  - Full, S without P: sample dropped; overflow_cnt +1, saturating at 255.
  - Full, S and P in the same cycle: both occur; level stays at DEPTH; no overflow counted.
  - Empty, P: impossible (out_valid=0).
  - Pointers wrap modulo DEPTH. fill_level is held as a separate count, or as pointers with an extra wrap bit.
- Flush:
  - Takes priority over S and P in the same cycle. FIFO is empty next cycle.
  - A coincident sample is discarded and is not counted as overflow. sample_strobe still pulses.
  - overflow_cnt and stuck are NOT cleared by flush.
- Stuck detection:
  - Tracks last_sample (4b), have_last (1b) and repeat count rc (4b).
  - On S: if have_last and rand == last_sample, rc+1 (saturating); otherwise rc=1. Then last_sample=rand and have_last=1.
  - When rc reaches STUCK_LIMIT, stuck=1 from the next cycle. It stays set until reset.
  - Tracking applies to all samples, including dropped and flushed ones.
- Reset mid-operation: all state is discarded immediately. The first event after release only counts if the nanos_q edge rule holds (nanos_q resets to 0).

Decomposition:
- Shared package random_pkg:
  - RAND_W=4, NANOS_W=28, and the source wrap constant 100000000.
  - Typedef for the rand value.
- One natural sub-module: rand_fifo. It is a synchronous first-word-fall-through FIFO with push, pop, flush, full, empty and level.
- random_sampler holds the event detect, the overflow counter and the stuck tracker.

Test Plan:
- Reset, then drive nanos 0,1,2,3 with rand=4'hA from nanos=1, out_ready=0. Expect sample_strobe pulse the cycle after nanos=2, out_valid=1, out_data=A, fill_level=1.
- Hold nanos=2 for 5 cycles. Expect exactly one sample, fill_level=1.
- 10 sample events with values 0..9, out_ready=0. Expect fill_level=8, overflow_cnt=2, FIFO holding 0..7. Then out_ready=1 for 8 cycles: out_data sequence 0..7, then out_valid=0.
- FIFO full and out_ready=1 during a sample event of value 5. Expect overflow_cnt unchanged, fill_level=8, tail entry=5.
- 4 consecutive events with rand=7 (STUCK_LIMIT=4). Expect stuck=1 after the 4th. Then flush plus a different value: stuck stays 1 and fill_level=0. Assert reset=0 mid-test: all outputs 0 immediately.
- flush asserted in the same cycle as a sample event and a pop on a 3-entry FIFO. Expect fill_level=0 next cycle, overflow_cnt unchanged, sample_strobe=1.

Source files
------------

// File: rtl/random_pkg.sv
// Shared widths and types for the random-source consumer blocks.
package random_pkg;
    localparam int RAND_W   = 4;
    localparam int NANOS_W  = 28;
    localparam int SRC_WRAP = 100_000_000;
    localparam int OVF_W    = 8;
    localparam int RC_W     = 4;

    typedef logic [RAND_W-1:0] rand_t;
endpackage

// File: rtl/rand_fifo.sv
// First-word-fall-through FIFO for captured random values; head is a register
// so the output stays steady while the FIFO is empty.
module rand_fifo
    import random_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     push,
    input  rand_t                    push_data,
    input  logic                     pop,
    input  logic                     flush,
    output rand_t                    head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    rand_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  rd_next;
    logic [AW:0]    count;
    logic [AW:0]    count_after_pop;
    logic [AW:0]    count_next;
    rand_t          head_q;
    rand_t          head_next;
    logic           accept;
    logic           do_pop;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign level = count;
    assign head  = head_q;

    // A push into a full FIFO is accepted only when a pop frees the slot at the same edge.
    always_comb begin
        do_pop          = pop && !empty;
        accept          = push && (!full || do_pop);
        rd_next         = rd_ptr + AW'(do_pop);
        count_after_pop = count - (AW+1)'(do_pop);
        count_next      = count_after_pop + (AW+1)'(accept);
        head_next       = (count_after_pop == '0) ? push_data : mem[rd_next];
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head_q <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_next;
            count <= count_next;
            if (count_next != '0) head_q <= head_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept && !flush) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/random_sampler.sv
// Captures one random value per source period, buffers it, and tracks
// dropped samples and a stuck source.
module random_sampler
    import random_pkg::*;
#(
    parameter int SAMPLE_AT   = 2,
    parameter int DEPTH       = 8,
    parameter int STUCK_LIMIT = 4
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic [NANOS_W-1:0]  nanos,
    input  rand_t               rand_value,
    input  logic                flush,
    input  logic                out_ready,
    output logic                out_valid,
    output rand_t               out_data,
    output logic [3:0]          fill_level,
    output logic [OVF_W-1:0]    overflow_cnt,
    output logic                stuck,
    output logic                sample_strobe
);
    localparam logic [NANOS_W-1:0] SAMPLE_POINT = NANOS_W'(SAMPLE_AT % SRC_WRAP);
    localparam logic [RC_W-1:0]    STUCK_AT     = RC_W'(STUCK_LIMIT);

    logic [NANOS_W-1:0]      nanos_q;
    logic                    sample_evt;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_level;
    rand_t                   last_sample;
    logic                    have_last;
    logic [RC_W-1:0]         rc;
    logic [RC_W-1:0]         rc_next;
    logic                    drop;

    // Output handshake: out_valid means out_data holds the oldest entry; a value
    // is consumed at the rising edge where out_valid && out_ready, and out_data
    // is held unchanged whenever out_valid is low.
    assign sample_evt = (nanos == SAMPLE_POINT) && (nanos_q != SAMPLE_POINT);
    assign pop        = out_valid && out_ready;
    assign out_valid  = !fifo_empty;
    assign fill_level = 4'(fifo_level);
    assign drop       = sample_evt && !flush && fifo_full && !pop;

    always_comb begin
        rc_next = RC_W'(1);
        if (have_last && (rand_value == last_sample))
            rc_next = (rc == '1) ? rc : rc + 1'b1;
    end

    rand_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK       (CLK),
        .reset     (reset),
        .push      (sample_evt),
        .push_data (rand_value),
        .pop       (pop),
        .flush     (flush),
        .head      (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            nanos_q       <= '0;
            sample_strobe <= 1'b0;
            overflow_cnt  <= '0;
        end else begin
            nanos_q       <= nanos;
            sample_strobe <= sample_evt;
            if (drop && (overflow_cnt != '1)) overflow_cnt <= overflow_cnt + 1'b1;
        end
    end

    // Dropped and flushed samples still feed the repeat tracker.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            last_sample <= '0;
            have_last   <= 1'b0;
            rc          <= '0;
            stuck       <= 1'b0;
        end else if (sample_evt) begin
            last_sample <= rand_value;
            have_last   <= 1'b1;
            rc          <= rc_next;
            if (rc_next >= STUCK_AT) stuck <= 1'b1;
        end
    end
endmodule

// File: tb/tb_random_sampler.sv
// Randomized and directed checks of random_sampler against a queue-based reference.
module tb_random_sampler;
    import random_pkg::*;

    localparam int SAMPLE_AT   = 2;
    localparam int DEPTH       = 8;
    localparam int STUCK_LIMIT = 4;

    logic        CLK        = 1'b0;
    logic        reset      = 1'b1;
    logic [27:0] nanos      = '0;
    logic [3:0]  rand_value = '0;
    logic        flush      = 1'b0;
    logic        out_ready  = 1'b0;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [3:0]  fill_level;
    logic [7:0]  overflow_cnt;
    logic        stuck;
    logic        sample_strobe;

    always #5 CLK = ~CLK;

    random_sampler #(
        .SAMPLE_AT(SAMPLE_AT), .DEPTH(DEPTH), .STUCK_LIMIT(STUCK_LIMIT)
    ) dut (
        .CLK           (CLK),
        .reset         (reset),
        .nanos         (nanos),
        .rand_value    (rand_value),
        .flush         (flush),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .fill_level    (fill_level),
        .overflow_cnt  (overflow_cnt),
        .stuck         (stuck),
        .sample_strobe (sample_strobe)
    );

    // Scoreboard: values the FIFO must still deliver, oldest first.
    logic [3:0]  exp_q[$];
    int          compared   = 0;
    int          mismatched = 0;

    // Reference state derived from the sampling rules.
    int          prev_nanos = 0;
    int          exp_ovf    = 0;
    bit          exp_stuck  = 0;
    bit          exp_strobe = 0;
    bit          have_last  = 0;
    int          last_val   = 0;
    int          run_len    = 0;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted handshake must present the next expected value.
    always @(negedge CLK) begin
        if (reset && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL pop_unexpected: got data %0d expected no valid output", out_data);
            end else begin
                chk("pop_data", int'(out_data), int'(exp_q.pop_front()));
            end
        end
    end

    // One clock cycle: check current outputs, then apply inputs and predict their effect.
    task automatic drive(input int n, input int r, input bit f, input bit rdy);
        bit s;
        bit pop;
        int lvl;
        @(posedge CLK);
        #1;
        lvl = exp_q.size();
        chk("fill_level", int'(fill_level), lvl);
        chk("out_valid", int'(out_valid), int'(lvl > 0));
        if (lvl > 0) chk("out_data", int'(out_data), int'(exp_q[0]));
        chk("overflow_cnt", int'(overflow_cnt), exp_ovf);
        chk("stuck", int'(stuck), int'(exp_stuck));
        chk("sample_strobe", int'(sample_strobe), int'(exp_strobe));

        nanos      = 28'(n);
        rand_value = 4'(r);
        flush      = f;
        out_ready  = rdy;

        s          = (n == SAMPLE_AT) && (prev_nanos != SAMPLE_AT);
        prev_nanos = n;
        pop        = (lvl > 0) && rdy && !f;
        if (s) begin
            run_len   = (have_last && r == last_val) ? run_len + 1 : 1;
            last_val  = r;
            have_last = 1;
            if (run_len >= STUCK_LIMIT) exp_stuck = 1;
            if (!f) begin
                if (lvl < DEPTH || pop) exp_q.push_back(4'(r));
                else if (exp_ovf < 255) exp_ovf++;
            end
        end
        if (f) exp_q.delete();
        exp_strobe = s;
    endtask

    task automatic sample(input int v, input bit rdy);
        drive(1, v, 0, rdy);
        drive(SAMPLE_AT, v, 0, rdy);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        reset      = 1'b0;
        nanos      = '0;
        rand_value = '0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_fill_level", int'(fill_level), 0);
        chk("rst_overflow_cnt", int'(overflow_cnt), 0);
        chk("rst_stuck", int'(stuck), 0);
        chk("rst_sample_strobe", int'(sample_strobe), 0);
        exp_q.delete();
        prev_nanos = 0;
        exp_ovf    = 0;
        exp_stuck  = 0;
        exp_strobe = 0;
        have_last  = 0;
        run_len    = 0;
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        do_reset();

        // First capture on the nanos edge.
        drive(0, 0, 0, 0);
        drive(1, 4'hA, 0, 0);
        drive(2, 4'hA, 0, 0);
        drive(3, 4'hA, 0, 0);
        drive(3, 4'hA, 0, 0);

        // nanos parked on the sample point yields a single capture.
        drive(1, 4'hB, 0, 0);
        repeat (5) drive(2, 4'hB, 0, 0);
        drive(3, 4'hB, 0, 0);
        repeat (3) drive(3, 0, 0, 1);

        // Overfill: ten samples into eight slots, then drain.
        do_reset();
        for (int i = 0; i < 10; i++) sample(i, 0);
        drive(3, 0, 0, 0);
        repeat (9) drive(3, 0, 0, 1);

        // Full FIFO with a pop in the same cycle as a sample.
        for (int i = 0; i < 8; i++) sample(i, 0);
        drive(1, 5, 0, 0);
        drive(2, 5, 0, 1);
        drive(3, 5, 0, 0);
        repeat (9) drive(3, 0, 0, 1);

        // Repeated value raises stuck; flush leaves it set.
        for (int i = 0; i < 4; i++) sample(7, 0);
        drive(3, 7, 0, 0);
        drive(1, 3, 0, 0);
        drive(2, 3, 1, 0);
        drive(3, 3, 0, 0);
        drive(3, 3, 0, 0);
        sample(6, 0);
        sample(9, 0);
        drive(3, 0, 0, 0);
        do_reset();

        // Flush coinciding with a sample and a pop on a three-entry FIFO.
        sample(1, 0);
        sample(2, 0);
        sample(3, 0);
        drive(1, 9, 0, 0);
        drive(2, 9, 1, 1);
        drive(3, 0, 0, 0);
        drive(3, 0, 0, 0);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 15) == 0), bit'($urandom_range(0, 1)));
        end
        repeat (10) drive(3, 0, 0, 1);
        drive(3, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
